// File: rtl/log_capture_ctrl.sv
// rtl/log_capture_ctrl.sv - sample log capture window and GPIO readout controller
module log_capture_ctrl #(
    parameter int NB_DATA             = 16,
    parameter int NB_ADDR             = 10,
    parameter int NB_LOG_READ_DEVICES = 2,
    parameter int NB_GPIOS            = 32
) (
    input  logic                                          clock,
    input  logic                                          in_reset,
    input  logic                                          in_run,
    input  logic [NB_LOG_READ_DEVICES-1:0]                in_device_sel,
    input  logic [(2**NB_LOG_READ_DEVICES)*NB_DATA-1:0]   in_sample_data,
    input  logic                                          in_sample_valid,
    input  logic                                          in_read_req,
    output logic [NB_GPIOS-1:0]                           out_log_capture_data,
    output logic                                          out_busy,
    output logic                                          out_full
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam int               DEPTH     = 2**NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

    logic [1:0]                     state_q, state_d;
    logic [NB_LOG_READ_DEVICES-1:0] sel_q, sel_d;
    logic [NB_ADDR-1:0]             wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR-1:0]             rd_ptr_q, rd_ptr_d;
    logic                           run_dly_q, run_dly_d;
    logic                           req_dly_q, req_dly_d;

    // read pipeline stage 1: request captured alongside the RAM read
    logic                           rd_vld_q, rd_vld_d;
    logic                           rd_ok_q, rd_ok_d;
    logic [NB_ADDR-1:0]             rd_addr_q, rd_addr_d;
    logic                           rd_ack_q, rd_ack_d;

    // read pipeline stage 2: word presented to the micro
    logic [NB_DATA-1:0]             data_q, data_d;
    logic [NB_ADDR-1:0]             addr_q, addr_d;
    logic                           ack_q, ack_d;

    logic [NB_DATA-1:0]             ram [DEPTH];
    logic [NB_DATA-1:0]             ram_rdata_q;

    logic                           run_rise;
    logic                           read_toggle;
    logic                           wr_en;
    logic [NB_DATA-1:0]             wr_data;

    // Capture FSM, pointer updates and read pipeline next-state
    always_comb begin
        run_rise    = in_run & ~run_dly_q;
        read_toggle = in_read_req ^ req_dly_q;
        wr_data     = in_sample_data[int'(sel_q)*NB_DATA +: NB_DATA];
        wr_en       = 1'b0;

        state_d   = state_q;
        sel_d     = sel_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        run_dly_d = in_run;
        req_dly_d = in_read_req;

        case (state_q)
            ST_IDLE: begin
                if (run_rise) begin
                    state_d  = ST_CAPTURE;
                    sel_d    = in_device_sel;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            ST_CAPTURE: begin
                // dropping run discards the partial window
                if (!in_run) begin
                    state_d = ST_IDLE;
                end else if (in_sample_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (read_toggle) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                // a restart overrides the read pointer advance; the read
                // issued this cycle still sees the old contents
                if (run_rise) begin
                    state_d  = ST_CAPTURE;
                    sel_d    = in_device_sel;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_vld_d  = read_toggle;
        rd_ok_d   = read_toggle && (state_q == ST_DONE);
        rd_addr_d = rd_ptr_q;
        rd_ack_d  = in_read_req;

        data_d = data_q;
        addr_d = addr_q;
        ack_d  = ack_q;
        if (rd_vld_q) begin
            data_d = rd_ok_q ? ram_rdata_q : '0;
            addr_d = rd_ok_q ? rd_addr_q : '0;
            ack_d  = rd_ack_q;
        end
    end

    // Control and pipeline registers
    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            run_dly_q <= 1'b0;
            req_dly_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_ok_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_ack_q  <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            run_dly_q <= run_dly_d;
            req_dly_q <= req_dly_d;
            rd_vld_q  <= rd_vld_d;
            rd_ok_q   <= rd_ok_d;
            rd_addr_q <= rd_addr_d;
            rd_ack_q  <= rd_ack_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            ack_q     <= ack_d;
        end
    end

    // Log RAM: contents survive reset, read is registered every cycle
    always_ff @(posedge clock) begin
        if (wr_en) begin
            ram[wr_ptr_q] <= wr_data;
        end
        ram_rdata_q <= ram[rd_ptr_q];
    end

    // GPIO return word; busy/full come straight from the state register
    always_comb begin
        out_busy = (state_q == ST_CAPTURE);
        out_full = (state_q == ST_DONE);
        out_log_capture_data                        = '0;
        out_log_capture_data[NB_DATA-1:0]           = data_q;
        out_log_capture_data[NB_DATA +: NB_ADDR]    = addr_q;
        out_log_capture_data[NB_GPIOS-3]            = ack_q;
        out_log_capture_data[NB_GPIOS-2]            = out_busy;
        out_log_capture_data[NB_GPIOS-1]            = out_full;
    end

endmodule

// File: tb/tb_log_capture_ctrl.sv
// tb/tb_log_capture_ctrl.sv - directed self-checking bench for log_capture_ctrl
module tb_log_capture_ctrl;

    localparam int NB_DATA = 16;
    localparam int NB_ADDR = 4;
    localparam int NB_DEV  = 2;
    localparam int NB_GPIO = 32;

    logic               clock = 1'b0;
    logic               in_reset;
    logic               in_run;
    logic [NB_DEV-1:0]  in_device_sel;
    logic [15:0]        src [4];
    logic [63:0]        in_sample_data;
    logic               in_sample_valid;
    logic               in_read_req;
    logic [31:0]        out_log_capture_data;
    logic               out_busy;
    logic               out_full;

    int errors = 0;
    int checks = 0;

    assign in_sample_data = {src[3], src[2], src[1], src[0]};

    always #5 clock = ~clock;

    log_capture_ctrl #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR),
        .NB_LOG_READ_DEVICES(NB_DEV),
        .NB_GPIOS(NB_GPIO)
    ) dut (
        .clock(clock),
        .in_reset(in_reset),
        .in_run(in_run),
        .in_device_sel(in_device_sel),
        .in_sample_data(in_sample_data),
        .in_sample_valid(in_sample_valid),
        .in_read_req(in_read_req),
        .out_log_capture_data(out_log_capture_data),
        .out_busy(out_busy),
        .out_full(out_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic full, input logic busy, input logic ack,
                                         input logic [3:0] addr, input logic [15:0] data);
        return {full, busy, ack, 9'd0, addr, data};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // toggle the request and wait out the two-cycle read latency
    task automatic do_read(input string tag, input logic full, input logic [3:0] addr,
                           input logic [15:0] data);
        in_read_req = ~in_read_req;
        tick();
        tick();
        check(tag, out_log_capture_data, word(full, 1'b0, in_read_req, addr, data));
    endtask

    initial begin
        in_reset        = 1'b1;
        in_run          = 1'b0;
        in_device_sel   = '0;
        in_sample_valid = 1'b0;
        in_read_req     = 1'b0;
        src[0] = 16'hFFFF; src[1] = 16'hFFFF; src[2] = 16'hFFFF; src[3] = 16'hFFFF;
        #1;
        check("rst_word", out_log_capture_data, 32'h0);
        check("rst_flags", {30'd0, out_busy, out_full}, 32'h0);
        tick();
        tick();
        in_reset = 1'b0;
        tick();

        // full capture from source 2
        in_device_sel = 2'd2;
        in_run        = 1'b1;
        tick();
        check("cap_busy", {30'd0, out_busy, out_full}, 32'h2);
        in_device_sel = 2'd0;
        for (int i = 0; i < 16; i++) begin
            in_sample_valid = 1'b1;
            src[2] = 16'h2000 + 16'(i);
            tick();
            if (i == 14) check("cap_not_full", {30'd0, out_busy, out_full}, 32'h2);
        end
        in_sample_valid = 1'b0;
        src[2] = 16'hFFFF;
        check("cap_full", {30'd0, out_busy, out_full}, 32'h1);
        check("cap_word_flags", {30'd0, out_log_capture_data[31:30]}, 32'h2);

        // latency: after one cycle the word must not yet have changed
        in_read_req = ~in_read_req;
        tick();
        check("lat_hold", out_log_capture_data, word(1'b1, 1'b0, 1'b0, 4'd0, 16'h0));
        tick();
        check("rd_0", out_log_capture_data, word(1'b1, 1'b0, 1'b1, 4'd0, 16'h2000));
        for (int i = 1; i < 17; i++) begin
            do_read($sformatf("rd_%0d", i), 1'b1, 4'(i % 16), 16'h2000 + 16'(i % 16));
        end

        // back-to-back toggles: rd_ptr is now 1, in_read_req is 1
        in_read_req = 1'b0;
        tick();
        in_read_req = 1'b1;
        tick();
        check("b2b_a", out_log_capture_data, word(1'b1, 1'b0, 1'b0, 4'd1, 16'h2001));
        in_read_req = 1'b0;
        tick();
        check("b2b_b", out_log_capture_data, word(1'b1, 1'b0, 1'b1, 4'd2, 16'h2002));
        tick();
        check("b2b_c", out_log_capture_data, word(1'b1, 1'b0, 1'b0, 4'd3, 16'h2003));

        // run falling keeps DONE
        in_run = 1'b0;
        tick();
        check("done_hold", {30'd0, out_busy, out_full}, 32'h1);

        // restart from source 1 with a same-cycle toggle and a rise-cycle valid
        in_run          = 1'b1;
        in_device_sel   = 2'd1;
        in_read_req     = 1'b1;
        in_sample_valid = 1'b1;
        src[1]          = 16'hBEEF;
        tick();
        check("rs_flags", {30'd0, out_busy, out_full}, 32'h2);
        in_device_sel = 2'd3;
        src[3]        = 16'h3333;
        for (int j = 0; j < 16; j++) begin
            in_sample_valid = 1'b1;
            src[1] = 16'h1000 + 16'(j);
            tick();
            if (j == 0) check("rs_old_read", out_log_capture_data,
                              word(1'b0, 1'b1, 1'b1, 4'd4, 16'h2004));
            in_sample_valid = 1'b0;
            src[1] = 16'hBEEF;
            tick();
            tick();
        end
        check("gap_full", {30'd0, out_busy, out_full}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            do_read($sformatf("gap_%0d", i), 1'b1, 4'(i), 16'h1000 + 16'(i));
        end

        // abort after 5 writes
        in_run = 1'b0;
        tick();
        in_run        = 1'b1;
        in_device_sel = 2'd0;
        tick();
        check("ab_busy", {30'd0, out_busy, out_full}, 32'h2);
        for (int i = 0; i < 5; i++) begin
            in_sample_valid = 1'b1;
            src[0] = 16'h0A00 + 16'(i);
            tick();
        end
        in_sample_valid = 1'b0;
        in_run          = 1'b0;
        tick();
        check("ab_flags", {30'd0, out_busy, out_full}, 32'h0);
        do_read("ab_read", 1'b0, 4'd0, 16'h0);

        // asynchronous reset in the middle of a capture
        in_run = 1'b1;
        tick();
        in_sample_valid = 1'b1;
        tick();
        tick();
        check("mr_busy", {30'd0, out_busy, out_full}, 32'h2);
        #3;
        in_reset        = 1'b1;
        in_run          = 1'b0;
        in_sample_valid = 1'b0;
        in_read_req     = 1'b0;
        #1;
        check("mr_word", out_log_capture_data, 32'h0);
        check("mr_flags", {30'd0, out_busy, out_full}, 32'h0);
        tick();
        in_reset = 1'b0;
        tick();
        check("post_idle", {30'd0, out_busy, out_full}, 32'h0);

        // after reset a fresh capture starts at address 0
        in_run        = 1'b1;
        in_device_sel = 2'd3;
        tick();
        for (int i = 0; i < 16; i++) begin
            in_sample_valid = 1'b1;
            src[3] = 16'h3000 + 16'(i);
            tick();
        end
        in_sample_valid = 1'b0;
        check("post_full", {30'd0, out_busy, out_full}, 32'h1);
        do_read("post_rd0", 1'b1, 4'd0, 16'h3000);
        do_read("post_rd1", 1'b1, 4'd1, 16'h3001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
